// File: rtl/switch_hit_judge_if.sv
// Handshake between the game FSM and the switch hit judge.
// The game FSM is the master: it starts rounds and ends windows; the judge reports the verdicts.
interface switch_hit_judge_if #(
  parameter int WIDTH = 16
);
  logic             arm;
  logic [WIDTH-1:0] target;
  logic             window_end;
  logic             hit;
  logic             miss;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output arm, target, window_end,
    input  hit, miss, busy, state
  );

  modport slave (
    input  arm, target, window_end,
    output hit, miss, busy, state
  );
endinterface

// File: rtl/switch_hit_judge.sv
// Switch conditioning (2-flop sync + per-bit debounce + toggle pulses) and
// per-round hit/miss judgement against the lit pattern latched at arm.
module switch_hit_judge #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    sw_raw,
  output logic [WIDTH-1:0]    sw_clean,
  output logic [WIDTH-1:0]    sw_toggle,
  switch_hit_judge_if.slave   judge
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HIT   = 2'b10,
    MISS  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] toggle_q;

  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] acc;
  state_t           state_q;
  logic             hit_q;
  logic             miss_q;

  logic [WIDTH-1:0] seen;
  logic             stray;
  logic             complete;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // A bit's counter runs only while the synced level disagrees with the accepted
  // level; any return to agreement restarts it, so short glitches never land.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      clean_q  <= '0;
      toggle_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        toggle_q[i] <= 1'b0;
        if (sync2[i] == clean_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]      <= '0;
          clean_q[i]  <= sync2[i];
          toggle_q[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign seen     = acc | toggle_q;
  assign stray    = |(toggle_q & ~target_q);
  assign complete = (target_q != '0) && ((seen & target_q) == target_q);

  // Verdicts are registered alongside the state so hit/miss are high exactly
  // while the FSM sits in HIT/MISS.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      target_q <= '0;
      acc      <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (judge.arm) begin
            target_q <= judge.target;
            acc      <= '0;
            state_q  <= ARMED;
          end
        end
        ARMED: begin
          if (judge.arm) begin
            target_q <= judge.target;
            acc      <= '0;
          end else if (stray) begin
            state_q <= MISS;
            miss_q  <= 1'b1;
          end else if (complete) begin
            state_q <= HIT;
            hit_q   <= 1'b1;
          end else if (judge.window_end) begin
            if (target_q == '0) begin
              state_q <= HIT;
              hit_q   <= 1'b1;
            end else begin
              state_q <= MISS;
              miss_q  <= 1'b1;
            end
          end else begin
            acc <= seen;
          end
        end
        HIT:     state_q <= IDLE;
        MISS:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_clean    = clean_q;
  assign sw_toggle   = toggle_q;
  assign judge.hit   = hit_q;
  assign judge.miss  = miss_q;
  assign judge.busy  = (state_q == ARMED);
  assign judge.state = state_q;

endmodule
